// File: rtl/qbert_move_sequencer.sv
// Qbert move sequencer: arbitrates SPI/Nios jump requests into a FIFO and
// launches one move per frame into the Qbert engine.
//   iCLK/iRST_n      clock, synchronous active-low reset
//   iEnable/iPause   game enable / launch freeze
//   iNewFrame        frame boundary pulse
//   iReq_*/iDir_*    held jump requests, oAck_* one-cycle accepts
//   oStart_qb/oJump_qb  move launch pulse and direction
//   iDone_move/iKO   engine move-complete pulse and KO level
//   oBusy/oCount/oBadCnt/oTimeout  status
module qbert_move_sequencer #(
  parameter int          DEPTH   = 4,
  parameter logic [23:0] TIMEOUT = 24'd4000000
) (
  input  logic                       iCLK,
  input  logic                       iRST_n,
  input  logic                       iEnable,
  input  logic                       iPause,
  input  logic                       iNewFrame,
  input  logic                       iReq_spi,
  input  logic [2:0]                 iDir_spi,
  output logic                       oAck_spi,
  input  logic                       iReq_cpu,
  input  logic [2:0]                 iDir_cpu,
  output logic                       oAck_cpu,
  output logic                       oStart_qb,
  output logic [2:0]                 oJump_qb,
  input  logic                       iDone_move,
  input  logic                       iKO,
  output logic                       oBusy,
  output logic [$clog2(DEPTH+1)-1:0] oCount,
  output logic [7:0]                 oBadCnt,
  output logic                       oTimeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_MOVE, S_KO
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;
  logic [7:0]    bad_q, bad_d;
  logic [23:0]   timer_q, timer_d;
  logic          ack_spi_q, ack_spi_d;
  logic          ack_cpu_q, ack_cpu_d;
  logic          start_q, start_d;
  logic [2:0]    jump_q, jump_d;
  logic          tmo_q, tmo_d;

  logic          can_acc, rs, rc, pop;
  logic          g_spi, g_cpu, p_spi, p_cpu;
  logic [CW:0]   free;
  logic [1:0]    nbad;
  logic [8:0]    bad_sum;
  logic [AW-1:0] wp;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    jump_d    = jump_q;
    start_d   = 1'b0;
    tmo_d     = 1'b0;
    g_spi     = 1'b0;
    g_cpu     = 1'b0;

    can_acc = iEnable && !iKO && (state_q != S_KO);
    // the requester still holds req in the cycle it sees ack
    rs  = iReq_spi && !ack_spi_q;
    rc  = iReq_cpu && !ack_cpu_q;
    pop = (state_q == S_START) && iEnable
          && !iKO && (count_q != '0);
    free = DEPTH_W - {1'b0, count_q}
           + {{CW{1'b0}}, pop};

    if (can_acc) begin
      if (rs && rc) begin
        if (free >= (CW+1)'(2)) begin
          g_spi = 1'b1;
          g_cpu = 1'b1;
        end else if (free == (CW+1)'(1)) begin
          g_spi = !rr_q;
          g_cpu = rr_q;
          rr_d  = !rr_q;
        end
      end else if (free != '0) begin
        g_spi = rs;
        g_cpu = rc;
      end
    end
    ack_spi_d = g_spi;
    ack_cpu_d = g_cpu;

    p_spi = g_spi && !iDir_spi[2];
    p_cpu = g_cpu && !iDir_cpu[2];
    nbad  = 2'(g_spi && iDir_spi[2])
          + 2'(g_cpu && iDir_cpu[2]);
    bad_sum = {1'b0, bad_q} + 9'(nbad);
    bad_d = bad_sum[8] ? 8'hff : bad_sum[7:0];

    if (pop) begin
      jump_d = {1'b0, mem_q[rd_q]};
      rd_d   = rd_q + AW'(1);
    end
    // SPI entry lands ahead of the CPU entry
    wp = wr_q;
    if (p_spi) begin
      mem_d[wp] = iDir_spi[1:0];
      wp = wp + AW'(1);
    end
    if (p_cpu) begin
      mem_d[wp] = iDir_cpu[1:0];
      wp = wp + AW'(1);
    end
    wr_d = wp;
    count_d = count_q - CW'(pop)
            + CW'(p_spi) + CW'(p_cpu);

    if (iKO || !iEnable) begin
      state_d = iKO ? S_KO : S_IDLE;
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (count_q != '0 && !iPause)
            state_d = S_WAIT;
        S_WAIT:
          if (iPause)
            state_d = S_IDLE;
          else if (iNewFrame)
            state_d = S_START;
        S_START: begin
          start_d = 1'b1;
          timer_d = '0;
          state_d = S_MOVE;
        end
        S_MOVE:
          if (iDone_move)
            state_d = S_IDLE;
          else if (timer_q == TIMEOUT - 24'd1) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end else
            timer_d = timer_q + 24'd1;
        S_KO:
          state_d = S_IDLE;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      rr_q      <= 1'b0;
      bad_q     <= '0;
      timer_q   <= '0;
      ack_spi_q <= 1'b0;
      ack_cpu_q <= 1'b0;
      start_q   <= 1'b0;
      jump_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
      bad_q     <= bad_d;
      timer_q   <= timer_d;
      ack_spi_q <= ack_spi_d;
      ack_cpu_q <= ack_cpu_d;
      start_q   <= start_d;
      jump_q    <= jump_d;
      tmo_q     <= tmo_d;
    end
  end

  assign oAck_spi  = ack_spi_q;
  assign oAck_cpu  = ack_cpu_q;
  assign oStart_qb = start_q;
  assign oJump_qb  = jump_q;
  assign oCount    = count_q;
  assign oBadCnt   = bad_q;
  assign oTimeout  = tmo_q;
  assign oBusy     = (state_q == S_WAIT)
                  || (state_q == S_START)
                  || (state_q == S_MOVE);

endmodule

// File: tb/tb_qbert_move_sequencer.sv
// Randomized bench for qbert_move_sequencer against a queue-based
// reference model of the move scheduling rules.
module tb_qbert_move_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, pause, nf;
  logic       req_s, req_c, done, ko;
  logic [2:0] dir_s, dir_c;
  logic       ack_s, ack_c, start, busy, tmo;
  logic [2:0] jump;
  logic [2:0] cnt;
  logic [7:0] bad;

  always #5 clk = ~clk;

  qbert_move_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT(24'(TMO))
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iEnable(en),
    .iPause(pause), .iNewFrame(nf),
    .iReq_spi(req_s), .iDir_spi(dir_s),
    .oAck_spi(ack_s),
    .iReq_cpu(req_c), .iDir_cpu(dir_c),
    .oAck_cpu(ack_c),
    .oStart_qb(start), .oJump_qb(jump),
    .iDone_move(done), .iKO(ko),
    .oBusy(busy), .oCount(cnt),
    .oBadCnt(bad), .oTimeout(tmo)
  );

  int total = 0;
  int bad_n = 0;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad_n++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model
  typedef enum {M_IDLE, M_WAIT, M_START, M_MOVE, M_KO} mode_t;
  mode_t m_mode;
  int    q[$];
  int    m_rr, m_bad, m_timer, m_jump;
  bit    m_ack_s, m_ack_c, m_start, m_tmo;

  task automatic model_step();
    int  n0, free, nb;
    bit  rs, rc, gs, gc, ok, pop;
    if (!rst_n) begin
      m_mode = M_IDLE; q.delete();
      m_rr = 0; m_bad = 0; m_timer = 0; m_jump = 0;
      m_ack_s = 0; m_ack_c = 0;
      m_start = 0; m_tmo = 0;
      return;
    end
    n0 = q.size();
    ok = en && !ko && m_mode != M_KO;
    pop = m_mode == M_START && en && !ko && n0 > 0;
    free = DEPTH - n0 + (pop ? 1 : 0);
    rs = req_s && !m_ack_s;
    rc = req_c && !m_ack_c;
    gs = 0; gc = 0;
    if (ok && rs && rc) begin
      if (free >= 2) begin gs = 1; gc = 1; end
      else if (free == 1) begin
        if (m_rr == 0) gs = 1; else gc = 1;
        m_rr = 1 - m_rr;
      end
    end else if (ok && free > 0) begin
      gs = rs; gc = rc;
    end
    m_ack_s = gs; m_ack_c = gc;
    m_start = 0; m_tmo = 0;
    if (pop) m_jump = q.pop_front();
    nb = 0;
    if (gs) begin
      if (dir_s < 4) q.push_back(int'(dir_s));
      else nb++;
    end
    if (gc) begin
      if (dir_c < 4) q.push_back(int'(dir_c));
      else nb++;
    end
    m_bad = (m_bad + nb > 255) ? 255 : m_bad + nb;
    if (ko) begin
      m_mode = M_KO; q.delete();
    end else if (!en) begin
      m_mode = M_IDLE; q.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (n0 > 0 && !pause) m_mode = M_WAIT;
        M_WAIT:
          if (pause) m_mode = M_IDLE;
          else if (nf) m_mode = M_START;
        M_START: begin
          m_start = 1; m_timer = 0;
          m_mode = M_MOVE;
        end
        M_MOVE:
          if (done) m_mode = M_IDLE;
          else if (m_timer == TMO - 1) begin
            m_tmo = 1; m_mode = M_IDLE;
          end else m_timer++;
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    bit mb;
    mb = m_mode == M_WAIT || m_mode == M_START
      || m_mode == M_MOVE;
    chk("ack_spi", int'(ack_s), int'(m_ack_s));
    chk("ack_cpu", int'(ack_c), int'(m_ack_c));
    chk("start", int'(start), int'(m_start));
    chk("jump", int'(jump), m_jump);
    chk("busy", int'(busy), int'(mb));
    chk("count", int'(cnt), q.size());
    chk("badcnt", int'(bad), m_bad);
    chk("timeout", int'(tmo), int'(m_tmo));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // requester behaviour: hold req through the ack cycle, drop after
  bit drop_s, drop_c;
  int bad_pct;

  function automatic logic [2:0] pick_dir();
    if ($urandom_range(99) < bad_pct)
      return 3'($urandom_range(7, 4));
    return 3'($urandom_range(3));
  endfunction

  task automatic drive();
    if (drop_s) begin req_s = 0; drop_s = 0; end
    else if (!req_s && $urandom_range(5) == 0) begin
      req_s = 1; dir_s = pick_dir();
    end
    if (drop_c) begin req_c = 0; drop_c = 0; end
    else if (!req_c && $urandom_range(5) == 0) begin
      req_c = 1; dir_c = pick_dir();
    end
    nf    = $urandom_range(14) == 0;
    done  = busy && $urandom_range(39) == 0;
    pause = $urandom_range(29) == 0;
    en    = $urandom_range(79) != 0;
    if (ko) ko = $urandom_range(5) != 0;
    else    ko = $urandom_range(149) == 0;
    rst_n = $urandom_range(399) != 0;
    if (!rst_n) begin
      req_s = 0; req_c = 0;
      drop_s = 0; drop_c = 0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      drive();
      cycle();
      if (m_ack_s) drop_s = 1;
      if (m_ack_c) drop_c = 1;
    end
  endtask

  initial begin
    rst_n = 0; en = 0; pause = 0; nf = 0;
    req_s = 0; req_c = 0; dir_s = 0; dir_c = 0;
    done = 0; ko = 0;
    drop_s = 0; drop_c = 0;
    bad_pct = 10;
    cycle();
    cycle();
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(cnt), 0);
    run(6000);
    // saturate the illegal-direction counter: no resets, all bad
    bad_pct = 100;
    for (int i = 0; i < 1500; i++) begin
      drive();
      rst_n = 1;
      ko = 0;
      en = 1;
      cycle();
      if (m_ack_s) drop_s = 1;
      if (m_ack_c) drop_c = 1;
    end
    chk("bad_sat", int'(bad), 255);
    bad_pct = 10;
    run(3000);
    $display("test done: total=%0d bad=%0d", total, bad_n);
    $finish;
  end

endmodule
